// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet receive path
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    BAD  = 2'd3
  } rx_state_t;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam int MAX_FRAME_BYTES = 1522;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_clr   synchronous clear (wins over i_inc)
//   i_inc   increment request, ignored once the count is all-ones
//   o_count current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rmii_frame_rx.sv
// rtl/rmii_frame_rx.sv - RMII preamble/SFD lock and payload dibit forwarder
// Ports:
//   clk, rst   50 MHz reference clock, synchronous active-high reset
//   crsdv, rxd RMII CRS_DV and RXD[1:0] from the PHY
//   axiov/axiod payload dibit stream (destination MAC through FCS), arrival order
//   sof/eof    first-payload pulse / pulse the cycle after the last payload dibit
//   frame_len  payload bytes, valid with eof and held until the next eof
//   frame_err  valid with eof: payload dibit count not a multiple of 4
//   err_count  saturating count of rejected preambles
module rmii_frame_rx
  import eth_pkg::*;
#(
  parameter int MIN_PRE = 8,
  parameter int MAX_PRE = 32,
  parameter int LEN_W   = $clog2(MAX_FRAME_BYTES + 1),
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crsdv,
  input  logic [1:0]       rxd,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             sof,
  output logic             eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int PRE_W = $clog2(MAX_PRE + 1);
  localparam int DIB_W = LEN_W + 2;

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_nxt;

  logic             r_axiov;
  logic [1:0]       r_axiod;
  logic             r_sof;
  logic             r_eof;
  logic [LEN_W-1:0] r_frame_len;
  logic             r_frame_err;

  logic             w_axiov_nxt;
  logic [1:0]       w_axiod_nxt;
  logic             w_sof_nxt;
  logic             w_eof_nxt;
  logic             w_len_load;
  logic             w_err_inc;
  logic             w_dib_inc;
  logic             w_dib_clr;
  logic [DIB_W-1:0] w_dib_cnt;
  logic [ERR_W-1:0] w_err_count;

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (1'b0),
    .i_inc   (w_err_inc),
    .o_count (w_err_count)
  );

  // Two spare bits below the byte count let frame_err see partial bytes.
  sat_counter #(.W(DIB_W)) u_dib_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_dib_clr),
    .i_inc   (w_dib_inc),
    .o_count (w_dib_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre_cnt;
    w_axiov_nxt = 1'b0;
    w_axiod_nxt = r_axiod;
    w_sof_nxt   = 1'b0;
    w_eof_nxt   = 1'b0;
    w_len_load  = 1'b0;
    w_err_inc   = 1'b0;
    w_dib_inc   = 1'b0;
    w_dib_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        // Anything other than a preamble dibit (typically 00) is idle filler.
        if (crsdv && (rxd == PRE_DIBIT)) begin
          w_state_nxt = PRE;
          w_pre_nxt   = PRE_W'(1);
        end
      end
      PRE: begin
        if (!crsdv) begin
          w_state_nxt = IDLE;
          w_err_inc   = 1'b1;
        end else if (rxd == PRE_DIBIT) begin
          w_pre_nxt = r_pre_cnt + 1'b1;
          if (r_pre_cnt == PRE_W'(MAX_PRE - 1)) begin
            w_state_nxt = BAD;
            w_err_inc   = 1'b1;
          end
        end else if ((rxd == SFD_DIBIT) && (r_pre_cnt >= PRE_W'(MIN_PRE))) begin
          w_state_nxt = DATA;
          w_dib_clr   = 1'b1;
        end else begin
          w_state_nxt = BAD;
          w_err_inc   = 1'b1;
        end
      end
      DATA: begin
        if (crsdv) begin
          w_axiov_nxt = 1'b1;
          w_axiod_nxt = rxd;
          w_dib_inc   = 1'b1;
          w_sof_nxt   = (w_dib_cnt == '0);
        end else begin
          // Single low cycle ends the frame; the mid-frame CRS_DV toggle is not decoded.
          w_state_nxt = IDLE;
          w_eof_nxt   = 1'b1;
          w_len_load  = 1'b1;
          w_dib_clr   = 1'b1;
        end
      end
      BAD: begin
        if (!crsdv) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pre_cnt   <= '0;
      r_axiov     <= 1'b0;
      r_axiod     <= 2'b00;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_len <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_axiov   <= w_axiov_nxt;
      r_axiod   <= w_axiod_nxt;
      r_sof     <= w_sof_nxt;
      r_eof     <= w_eof_nxt;
      if (w_len_load) begin
        r_frame_len <= w_dib_cnt[DIB_W-1:2];
        r_frame_err <= (w_dib_cnt[1:0] != 2'b00);
      end
    end
  end

  assign axiov     = r_axiov;
  assign axiod     = r_axiod;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign frame_len = r_frame_len;
  assign frame_err = r_frame_err;
  assign err_count = w_err_count;

endmodule

// File: tb/tb_rmii_frame_rx.sv
// tb/tb_rmii_frame_rx.sv - self-checking bench for rmii_frame_rx
module tb_rmii_frame_rx;

  localparam int MIN_PRE = 8;
  localparam int MAX_PRE = 32;
  localparam int LEN_W   = 11;
  localparam int ERR_W   = 8;

  typedef logic [1:0] dib_q_t[$];

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             crsdv = 1'b0;
  logic [1:0]       rxd   = 2'b00;
  logic             axiov;
  logic [1:0]       axiod;
  logic             sof;
  logic             eof;
  logic [LEN_W-1:0] frame_len;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  rmii_frame_rx #(
    .MIN_PRE (MIN_PRE),
    .MAX_PRE (MAX_PRE),
    .LEN_W   (LEN_W),
    .ERR_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .crsdv     (crsdv),
    .rxd       (rxd),
    .axiov     (axiov),
    .axiod     (axiod),
    .sof       (sof),
    .eof       (eof),
    .frame_len (frame_len),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec    = 0;
  int n_bad    = 0;
  int exp_errs = 0;

  // Everything the DUT emits, in order; checks look at slices of these.
  logic [1:0] q_got[$];
  int         sof_cyc_q[$];
  bit         sof_ok_q[$];
  int         eof_len_q[$];
  bit         eof_err_q[$];
  bit         eof_prev_q[$];
  logic       prev_axiov = 1'b0;

  always @(negedge clk) begin
    if (axiov) q_got.push_back(axiod);
    if (sof) begin
      sof_cyc_q.push_back(cyc);
      sof_ok_q.push_back(axiov && !prev_axiov);
    end
    if (eof) begin
      eof_len_q.push_back(int'(frame_len));
      eof_err_q.push_back(frame_err);
      eof_prev_q.push_back(prev_axiov);
    end
    prev_axiov <= axiov;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    end
  endtask

  // Reference: index of the first payload dibit, -1 for a rejected preamble,
  // -2 if the sequence never starts a preamble.
  function automatic int model(input dib_q_t s);
    int i = 0;
    int n = 0;
    while (i < s.size() && s[i] != 2'b01) i++;
    if (i == s.size()) return -2;
    while (i < s.size() && s[i] == 2'b01) begin
      n++;
      i++;
      if (n >= MAX_PRE) return -1;
    end
    if (i == s.size()) return -1;
    if (s[i] == 2'b11 && n >= MIN_PRE) return i + 1;
    return -1;
  endfunction

  function automatic dib_q_t build(input int npre, input bit with_sfd,
                                   input logic [1:0] sfd, input int npay);
    dib_q_t s;
    repeat (npre) s.push_back(2'b01);
    if (with_sfd) s.push_back(sfd);
    repeat (npay) s.push_back(2'($urandom_range(0, 3)));
    return s;
  endfunction

  task automatic drv(input logic v, input logic [1:0] d);
    @(posedge clk);
    #1;
    crsdv = v;
    rxd   = d;
  endtask

  task automatic drive_frame(input dib_q_t s, output int gb, output int sb,
                             output int eb, output int kf);
    int ps;
    ps = model(s);
    kf = -1;
    gb = 0; sb = 0; eb = 0;
    foreach (s[i]) begin
      drv(1'b1, s[i]);
      if (i == ps) kf = cyc;
      if (i == 0) begin
        // Let any eof from a preceding back-to-back frame land first.
        @(negedge clk);
        #1;
        gb = q_got.size();
        sb = sof_cyc_q.size();
        eb = eof_len_q.size();
      end
    end
    drv(1'b0, 2'b00);
  endtask

  task automatic check_frame(input string tag, input dib_q_t s,
                             input int gb, input int ge, input int sb, input int se,
                             input int eb, input int ee, input int kf);
    int ps, np, mism;
    ps = model(s);
    if (ps == -1 && exp_errs < (1 << ERR_W) - 1) exp_errs++;
    if (ps < 0) begin
      chk({tag, ".axiov"}, ge - gb, 0);
      chk({tag, ".sof"}, se - sb, 0);
      chk({tag, ".eof"}, ee - eb, 0);
    end else begin
      np = s.size() - ps;
      chk({tag, ".ndib"}, ge - gb, np);
      mism = 0;
      if (ge - gb == np)
        for (int j = 0; j < np; j++)
          if (q_got[gb + j] !== s[ps + j]) mism++;
      chk({tag, ".data"}, mism, 0);
      chk({tag, ".neof"}, ee - eb, 1);
      if (ee - eb >= 1) begin
        chk({tag, ".len"}, eof_len_q[eb], np / 4);
        chk({tag, ".ferr"}, int'(eof_err_q[eb]), (np % 4 != 0) ? 1 : 0);
        chk({tag, ".eofpos"}, int'(eof_prev_q[eb]), (np > 0) ? 1 : 0);
      end
      chk({tag, ".nsof"}, se - sb, (np > 0) ? 1 : 0);
      if (np > 0 && se - sb >= 1) begin
        chk({tag, ".sofcyc"}, sof_cyc_q[sb], kf + 1);
        chk({tag, ".sofpos"}, int'(sof_ok_q[sb]), 1);
      end
    end
    chk({tag, ".errcnt"}, int'(err_count), exp_errs);
  endtask

  task automatic run(input string tag, input dib_q_t s);
    int gb, sb, eb, kf;
    drive_frame(s, gb, sb, eb, kf);
    repeat (3) drv(1'b0, 2'b00);
    check_frame(tag, s, gb, q_got.size(), sb, sof_cyc_q.size(), eb, eof_len_q.size(), kf);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".axiov"}, int'(axiov), 0);
    chk({tag, ".axiod"}, int'(axiod), 0);
    chk({tag, ".sof"}, int'(sof), 0);
    chk({tag, ".eof"}, int'(eof), 0);
    chk({tag, ".len"}, int'(frame_len), 0);
    chk({tag, ".ferr"}, int'(frame_err), 0);
    chk({tag, ".errcnt"}, int'(err_count), 0);
  endtask

  initial begin
    dib_q_t s, s2;
    logic [1:0] tp1[8];
    int ga, sa, ea, ka, gb2, sb2, eb2, kb, eb_rst, npre, sel;
    bit with_sfd;
    logic [1:0] sfd;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // long preamble, fixed payload pattern
    s = build(28, 1'b1, 2'b11, 0);
    tp1 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    foreach (tp1[i]) s.push_back(tp1[i]);
    run("tp1", s);

    // short preamble
    run("short_pre", build(4, 1'b1, 2'b11, 12));

    // bad dibit inside preamble, then a good frame
    s = build(10, 1'b0, 2'b00, 0);
    s.push_back(2'b10);
    s.push_back(2'b01);
    s.push_back(2'b11);
    repeat (8) s.push_back(2'($urandom_range(0, 3)));
    run("bad_dibit", s);
    run("after_bad", build(12, 1'b1, 2'b11, 16));

    // partial byte, preamble exactly MIN_PRE
    run("partial", build(MIN_PRE, 1'b1, 2'b11, 6));

    // SFD followed at once by carrier loss
    run("empty", build(10, 1'b1, 2'b11, 0));

    // preamble length boundaries around MAX_PRE
    run("pre_max_m1", build(MAX_PRE - 1, 1'b1, 2'b11, 9));
    run("pre_max", build(MAX_PRE, 1'b1, 2'b11, 9));

    // two 64-byte frames separated by a single crsdv=0 cycle
    s  = build(20, 1'b1, 2'b11, 256);
    s2 = build(20, 1'b1, 2'b11, 256);
    drive_frame(s, ga, sa, ea, ka);
    drive_frame(s2, gb2, sb2, eb2, kb);
    repeat (3) drv(1'b0, 2'b00);
    check_frame("b2b_1", s, ga, gb2, sa, sb2, ea, eb2, ka);
    check_frame("b2b_2", s2, gb2, q_got.size(), sb2, sof_cyc_q.size(), eb2, eof_len_q.size(), kb);

    // reset mid-payload
    s = build(12, 1'b1, 2'b11, 20);
    foreach (s[i]) drv(1'b1, s[i]);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    eb_rst = eof_len_q.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_rst");
    exp_errs = 0;
    repeat (3) drv(1'b0, 2'b00);
    chk("mid_rst.no_eof", eof_len_q.size() - eb_rst, 0);
    run("after_rst", build(9, 1'b1, 2'b11, 40));

    // randomized frames mixing good and malformed preambles
    for (int f = 0; f < 24; f++) begin
      s = {};
      repeat ($urandom_range(0, 3)) begin
        sel = $urandom_range(0, 2);
        s.push_back(sel == 0 ? 2'b00 : (sel == 1 ? 2'b10 : 2'b11));
      end
      case ($urandom_range(0, 5))
        0:       npre = MIN_PRE - 1;
        1:       npre = MIN_PRE;
        2:       npre = MAX_PRE - 1;
        3:       npre = MAX_PRE;
        default: npre = $urandom_range(MIN_PRE, MAX_PRE - 1);
      endcase
      sel = $urandom_range(0, 7);
      sfd = (sel == 6) ? 2'b00 : ((sel == 7) ? 2'b10 : 2'b11);
      with_sfd = ($urandom_range(0, 9) != 0);
      s2 = build(npre, with_sfd, sfd, with_sfd ? $urandom_range(0, 40) : 0);
      foreach (s2[i]) s.push_back(s2[i]);
      run($sformatf("rand%0d", f), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
